// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add sequencer.
package serial_add_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_full_adder.sv
// Single combinational full-adder cell shared across every bit position.
module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (b & ci) | (a & ci);

endmodule

// File: rtl/serial_add_sequencer.sv
// Valid/ready bit-serial adder: one full-adder cell, LSB-first, WIDTH cycles per op.
// Optional macro SERIAL_ADD_SUB_EN adds the sub port (a - b via ~b and carry-in 1).
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic               load_s;
    logic               step_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   sum_sh_r;
    logic               carry_r;
    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   b_load_s;
    logic               carry_load_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    bit_full_adder u_fa (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .ci (carry_r),
        .s  (fa_s),
        .co (fa_co)
    );

    // Operand/carry values captured on the accepting edge.
    always_comb begin
        b_load_s     = b;
        carry_load_s = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
`endif
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    load_s       = 1'b1;
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus registered handshake/status flags decoded from next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s == SHIFT);
        end
    end

    // Shift registers, carry and bit counter; the sum register doubles as the output.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            sum_sh_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
        end else if (load_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b_load_s;
            carry_r  <= carry_load_s;
            cnt_r    <= '0;
        end else if (step_s) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            sum_sh_r <= {fa_s, sum_sh_r[WIDTH-1:1]};
            carry_r  <= fa_co;
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            a_sh_r   <= a_sh_r;
            b_sh_r   <= b_sh_r;
            sum_sh_r <= sum_sh_r;
            carry_r  <= carry_r;
            cnt_r    <= cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_sh_r;
    assign cout      = carry_r;

endmodule
